// File: rtl/alineador_comas_if.sv
// Bundles the serial input, enable and aligned-symbol outputs of the comma aligner.
// master drives enb/serialIn and observes results; slave is the aligner itself.
interface alineador_comas_if;
  logic       enb;
  logic       serialIn;
  logic [9:0] symbolOut;
  logic       symbolValid;
  logic       commaDet;
  logic       locked;
  logic [1:0] state;

  modport master (
    output enb,
    output serialIn,
    input  symbolOut,
    input  symbolValid,
    input  commaDet,
    input  locked,
    input  state
  );

  modport slave (
    input  enb,
    input  serialIn,
    output symbolOut,
    output symbolValid,
    output commaDet,
    output locked,
    output state
  );
endinterface

// File: rtl/alineador_comas.sv
// Finds the 10-bit symbol boundary in a serial stream using K28.5 commas and emits aligned symbols.
// Symbols appear on the edge that shifts in their last bit; no backpressure, enb=0 freezes everything.
module alineador_comas #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4
) (
  input logic              clk,
  input logic              rst,
  alineador_comas_if.slave bus
);

  localparam logic [1:0] SEARCH   = 2'b00;
  localparam logic [1:0] ALIGNING = 2'b01;
  localparam logic [1:0] LOCKED   = 2'b10;

  localparam logic [9:0] COMMA_NEG = 10'h0FA;
  localparam logic [9:0] COMMA_POS = 10'h305;

  localparam logic [4:0] LOCK_N = 5'(LOCK_COUNT);
  localparam logic [4:0] LOSS_N = 5'(LOSS_COUNT);

  logic [9:0] win;
  logic [9:0] win_next;
  logic [3:0] phase;
  logic [3:0] cnt;
  logic [3:0] miss;
  logic [1:0] st;
  logic [9:0] sym;
  logic       sym_vld;
  logic       comma_vld;
  logic       lck;
  logic       comma;
  logic       boundary;
  logic [4:0] cnt_inc;
  logic [4:0] miss_inc;

  assign win_next = {win[8:0], bus.serialIn};
  assign comma    = (win_next == COMMA_NEG) || (win_next == COMMA_POS);
  assign boundary = (phase == 4'd9);
  // 5-bit sums so a count of 15 cannot wrap before the threshold compare
  assign cnt_inc  = {1'b0, cnt} + 5'd1;
  assign miss_inc = {1'b0, miss} + 5'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      win       <= '0;
      phase     <= '0;
      cnt       <= '0;
      miss      <= '0;
      st        <= SEARCH;
      sym       <= '0;
      sym_vld   <= 1'b0;
      comma_vld <= 1'b0;
      lck       <= 1'b0;
    end else begin
      sym_vld   <= 1'b0;
      comma_vld <= 1'b0;
      if (bus.enb) begin
        win   <= win_next;
        phase <= boundary ? 4'd0 : phase + 4'd1;
        case (st)
          SEARCH: begin
            if (comma) begin
              phase <= 4'd0;
              cnt   <= 4'd1;
              miss  <= 4'd0;
              if (LOCK_COUNT == 1) begin
                st        <= LOCKED;
                lck       <= 1'b1;
                sym       <= win_next;
                sym_vld   <= 1'b1;
                comma_vld <= 1'b1;
              end else begin
                st <= ALIGNING;
              end
            end
          end
          ALIGNING: begin
            if (comma) begin
              if (boundary) begin
                if (cnt_inc >= LOCK_N) begin
                  // the comma that completes alignment is the first symbol delivered
                  st        <= LOCKED;
                  lck       <= 1'b1;
                  miss      <= 4'd0;
                  sym       <= win_next;
                  sym_vld   <= 1'b1;
                  comma_vld <= 1'b1;
                end else begin
                  cnt <= cnt_inc[3:0];
                end
              end else begin
                phase <= 4'd0;
                cnt   <= 4'd1;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              sym     <= win_next;
              sym_vld <= 1'b1;
              if (comma) begin
                comma_vld <= 1'b1;
                miss      <= 4'd0;
              end
            end else if (comma) begin
              // repeated off-phase commas mean the boundary moved; reseed from this one
              if (miss_inc >= LOSS_N) begin
                phase <= 4'd0;
                cnt   <= 4'd1;
                miss  <= 4'd0;
                st    <= ALIGNING;
                lck   <= 1'b0;
              end else begin
                miss <= miss_inc[3:0];
              end
            end
          end
          default: st <= SEARCH;
        endcase
      end
    end
  end

  assign bus.symbolOut   = sym;
  assign bus.symbolValid = sym_vld;
  assign bus.commaDet    = comma_vld;
  assign bus.locked      = lck;
  assign bus.state       = st;

endmodule

// File: tb/tb_alineador_comas.sv
// Directed bench for alineador_comas: reference model of the alignment rules plus literal spot checks.
module tb_alineador_comas;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;

  alineador_comas_if ifc ();

  alineador_comas #(.LOCK_COUNT(3), .LOSS_COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // reference model state: bits counted since last resync instead of a phase register
  logic [9:0] m_win  = '0;
  logic [9:0] m_sym  = '0;
  int         m_since = 0;
  int         m_cnt   = 0;
  int         m_miss  = 0;
  int         m_state = 0;
  bit         m_val   = 1'b0;
  bit         m_cd    = 1'b0;
  bit         m_lock  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic emit(input logic [9:0] w, input bit cd);
    m_sym = w;
    m_val = 1'b1;
    m_cd  = cd;
  endtask

  task automatic model_step(input logic r, input logic e, input logic s);
    logic [9:0] nw;
    bit         is_comma;
    bit         on_bnd;
    if (!r) begin
      m_win = '0; m_sym = '0; m_since = 0; m_cnt = 0; m_miss = 0;
      m_state = 0; m_val = 1'b0; m_cd = 1'b0; m_lock = 1'b0;
    end else begin
      m_val = 1'b0;
      m_cd  = 1'b0;
      if (e) begin
        nw       = {m_win[8:0], s};
        is_comma = (nw == 10'h0FA) || (nw == 10'h305);
        on_bnd   = (m_since % 10) == 9;
        m_since++;
        m_win = nw;
        if (m_state == 0) begin
          if (is_comma) begin
            m_since = 0; m_cnt = 1; m_state = 1;
          end
        end else if (m_state == 1) begin
          if (is_comma && on_bnd) begin
            m_cnt++;
            if (m_cnt >= 3) begin
              m_state = 2; m_lock = 1'b1; m_miss = 0;
              emit(nw, 1'b1);
            end
          end else if (is_comma) begin
            m_since = 0; m_cnt = 1;
          end
        end else begin
          if (on_bnd) begin
            emit(nw, is_comma);
            if (is_comma) m_miss = 0;
          end else if (is_comma) begin
            m_miss++;
            if (m_miss >= 4) begin
              m_since = 0; m_cnt = 1; m_miss = 0; m_state = 1; m_lock = 1'b0;
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("symbolOut",   int'(ifc.symbolOut),   int'(m_sym));
      chk("symbolValid", int'(ifc.symbolValid), int'(m_val));
      chk("commaDet",    int'(ifc.commaDet),    int'(m_cd));
      chk("locked",      int'(ifc.locked),      int'(m_lock));
      chk("state",       int'(ifc.state),       m_state);
    end
  end

  task automatic tick(input logic r, input logic e, input logic s);
    @(negedge clk);
    rst = r;
    ifc.enb = e;
    ifc.serialIn = s;
    @(posedge clk);
    model_step(r, e, s);
    #1;
  endtask

  task automatic send_sym(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) tick(1'b1, 1'b1, v[i]);
  endtask

  task automatic send_bits(input logic [9:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) tick(1'b1, 1'b1, v[i]);
  endtask

  initial begin
    ifc.enb = 1'b0;
    ifc.serialIn = 1'b0;

    // 1: reset with toggling input
    tick(1'b0, 1'b1, 1'b1);
    run = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    chk("t1_symbolOut", int'(ifc.symbolOut), 0);
    chk("t1_valid", int'(ifc.symbolValid), 0);
    chk("t1_locked", int'(ifc.locked), 0);
    chk("t1_state", int'(ifc.state), 0);

    // 2: junk then three commas and a data symbol
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    send_sym(10'h0FA);
    chk("t2_state_c1", int'(ifc.state), 1);
    send_sym(10'h305);
    chk("t2_locked_c2", int'(ifc.locked), 0);
    send_sym(10'h0FA);
    chk("t2_locked_c3", int'(ifc.locked), 1);
    chk("t2_valid_c3", int'(ifc.symbolValid), 1);
    chk("t2_comma_c3", int'(ifc.commaDet), 1);
    chk("t2_sym_c3", int'(ifc.symbolOut), 'h0FA);
    send_sym(10'h2AA);
    chk("t2_sym_d", int'(ifc.symbolOut), 'h2AA);
    chk("t2_valid_d", int'(ifc.symbolValid), 1);
    chk("t2_comma_d", int'(ifc.commaDet), 0);

    // 3: two aligned commas, then a comma one bit early restarts the count
    tick(1'b0, 1'b1, 1'b0);
    send_sym(10'h0FA);
    send_sym(10'h305);
    send_bits(10'h2AA, 8, 0);
    send_sym(10'h0FA);
    chk("t3_state_resync", int'(ifc.state), 1);
    send_sym(10'h0FA);
    chk("t3_locked_after2", int'(ifc.locked), 0);
    send_sym(10'h0FA);
    chk("t3_locked_after3", int'(ifc.locked), 1);

    // 4: one-bit slip while locked
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send_sym(10'h0FA);
    chk("t4_locked_miss3", int'(ifc.locked), 1);
    send_sym(10'h0FA);
    chk("t4_locked_miss4", int'(ifc.locked), 0);
    chk("t4_state_miss4", int'(ifc.state), 1);
    send_sym(10'h0FA);
    chk("t4_state_re1", int'(ifc.state), 1);
    send_sym(10'h0FA);
    chk("t4_locked_re2", int'(ifc.locked), 1);
    chk("t4_sym_re2", int'(ifc.symbolOut), 'h0FA);

    // 5: enable gap mid-symbol
    send_sym(10'h2AA);
    chk("t5_valid_pre", int'(ifc.symbolValid), 1);
    send_bits(10'h16B, 9, 6);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, k[0]);
    chk("t5_valid_gap", int'(ifc.symbolValid), 0);
    send_bits(10'h16B, 5, 1);
    chk("t5_valid_early", int'(ifc.symbolValid), 0);
    send_bits(10'h16B, 0, 0);
    chk("t5_valid_post", int'(ifc.symbolValid), 1);
    chk("t5_sym_post", int'(ifc.symbolOut), 'h16B);

    // 6: reset while locked
    send_bits(10'h2AA, 9, 5);
    tick(1'b0, 1'b1, 1'b1);
    chk("t6_locked_rst", int'(ifc.locked), 0);
    chk("t6_state_rst", int'(ifc.state), 0);
    send_sym(10'h0FA);
    chk("t6_state_c1", int'(ifc.state), 1);
    send_sym(10'h0FA);
    chk("t6_locked_c2", int'(ifc.locked), 0);
    send_sym(10'h0FA);
    chk("t6_locked_c3", int'(ifc.locked), 1);
    chk("t6_comma_c3", int'(ifc.commaDet), 1);

    tick(1'b1, 1'b1, 1'b0);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
